imem_load_run_ctrl: RTL

//  Sequencer in front of RISCV_SingleCycle: streams a program into IMEM through the core's

---
 rtl/riscv_ctrl_pkg.sv | 18 +
 rtl/imem_load_run_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the IMEM load/run sequencer, the single-cycle core top and benches.
package riscv_ctrl_pkg;

    localparam int IMEM_DEPTH    = 64;
    localparam int INSTR_W       = 32;
    localparam int RUN_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        STEP,
        REWIND,
        RUN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/imem_load_run_ctrl.sv
// Streams a program into the core IMEM via the write/up/down pointer pins, rewinds the
// pointer to word 0, then runs the core until a cycle budget or halt-PC match.
module imem_load_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int LEN_W = $clog2(DEPTH) + 1,
    parameter int RUN_W = RUN_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_load,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic               instr_ready,
    input  logic               cmd_run,
    input  logic [RUN_W-1:0]   run_cycles,
    input  logic [31:0]        halt_pc,
    input  logic [31:0]        cpu_pc,
    output logic               cpu_start,
    output logic [INSTR_W-1:0] cpu_imem_wr_instr,
    output logic               cpu_imem_wr_en,
    output logic               cpu_up,
    output logic               cpu_down,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               err
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    ctrl_state_t        state_q, state_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [RUN_W-1:0]   budget_q, budget_d;
    logic [31:0]        halt_pc_q, halt_pc_d;
    logic [INSTR_W-1:0] wr_instr_q, wr_instr_d;
    logic               wr_en_q, wr_en_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [RUN_W-1:0]   run_next;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        run_cnt_d  = run_cnt_q;
        budget_d   = budget_q;
        halt_pc_d  = halt_pc_q;
        wr_instr_d = wr_instr_q;
        halted_d   = 1'b0;
        err_d      = 1'b0;
        run_next   = run_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_load) begin
                    err_d = cmd_run;
                    if (load_len > DEPTH_L) begin
                        err_d = 1'b1;
                    end else if (load_len == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d      = load_len;
                        word_cnt_d = '0;
                        state_d    = ACCEPT;
                    end
                end else if (cmd_run) begin
                    budget_d  = run_cycles;
                    halt_pc_d = halt_pc;
                    run_cnt_d = '0;
                    state_d   = (run_cycles == '0) ? DONE : RUN;
                end
            end
            ACCEPT: begin
                if (instr_valid) begin
                    wr_instr_d = instr_data;
                    state_d    = WRITE;
                end
            end
            WRITE: state_d = STEP;
            STEP: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == len_q) ? REWIND : ACCEPT;
            end
            // Word counter counts back down so REWIND lasts exactly load_len cycles.
            REWIND: begin
                word_cnt_d = word_cnt_q - 1'b1;
                if (word_cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
            end
            RUN: begin
                run_cnt_d = run_next;
                if (cpu_pc == halt_pc_q) begin
                    state_d  = DONE;
                    halted_d = 1'b1;
                end else if (run_next == budget_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (cmd_load || cmd_run)) begin
            err_d = 1'b1;
        end

        // Outputs are registered from the next state so each one tracks its state exactly.
        wr_en_d = (state_d == WRITE);
        up_d    = (state_d == STEP);
        down_d  = (state_d == REWIND);
        start_d = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            len_q      <= '0;
            run_cnt_q  <= '0;
            budget_q   <= '0;
            halt_pc_q  <= '0;
            wr_instr_q <= '0;
            wr_en_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            run_cnt_q  <= run_cnt_d;
            budget_q   <= budget_d;
            halt_pc_q  <= halt_pc_d;
            wr_instr_q <= wr_instr_d;
            wr_en_q    <= wr_en_d;
            up_q       <= up_d;
            down_q     <= down_d;
            start_q    <= start_d;
            done_q     <= done_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign instr_ready       = (state_q == ACCEPT);
    assign busy              = (state_q != IDLE);
    assign cpu_imem_wr_instr = wr_instr_q;
    assign cpu_imem_wr_en    = wr_en_q;
    assign cpu_up            = up_q;
    assign cpu_down          = down_q;
    assign cpu_start         = start_q;
    assign done              = done_q;
    assign halted            = halted_q;
    assign err               = err_q;

endmodule
